// File: rtl/lcd_window_writer_pkg.sv
// ============================================================================
// lcd_window_writer_pkg : ST7789V3 opcodes, RS encoding, panel defaults and
//                         window-writer state encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_window_writer_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int   RS_BIT  = 8;
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int LCD_W_DEF = 240;
  localparam int LCD_H_DEF = 320;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CASET  = 3'd1,
    ST_RASET  = 3'd2,
    ST_RAMWR  = 3'd3,
    ST_PIX_HI = 3'd4,
    ST_PIX_LO = 3'd5,
    ST_DONE   = 3'd6
  } wr_state_e;

  function automatic logic [RS_BIT:0] mk_word(input logic rs, input logic [7:0] b);
    return {rs, b};
  endfunction

  // Parameter index 1..4 -> start hi, start lo, end hi, end lo.
  function automatic logic [7:0] param_byte(input logic [2:0] idx,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    case (idx)
      3'd1:    return a[15:8];
      3'd2:    return a[7:0];
      3'd3:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_window_writer.sv
// ============================================================================
// lcd_window_writer : emits CASET/RASET/RAMWR and an RGB565 byte stream for
//                     one rectangular window into the LCD word FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_window_writer
  import lcd_window_writer_pkg::*;
#(
  parameter int WORD_WIDTH  = 9,
  parameter int COORD_WIDTH = 9,
  parameter int LCD_W       = LCD_W_DEF,
  parameter int LCD_H       = LCD_H_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] y1,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [15:0]            pix_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_data
);

  localparam int CNT_W = 2 * COORD_WIDTH;
  localparam logic [COORD_WIDTH-1:0] X_LIM = COORD_WIDTH'(LCD_W);
  localparam logic [COORD_WIDTH-1:0] Y_LIM = COORD_WIDTH'(LCD_H);

  wr_state_e             state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [COORD_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            lo_q, lo_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  slot_free;
  logic                  bad_window;
  logic [CNT_W-1:0]      span_x, span_y;
  logic [15:0]           par_a, par_b;

  assign slot_free  = !out_valid_q || out_ready;
  assign bad_window = (x1 < x0) || (y1 < y0) || (x1 >= X_LIM) || (y1 >= Y_LIM);
  assign span_x     = CNT_W'(x1) - CNT_W'(x0) + CNT_W'(1);
  assign span_y     = CNT_W'(y1) - CNT_W'(y0) + CNT_W'(1);
  assign par_a      = (state_q == ST_CASET) ? 16'(x0_q) : 16'(y0_q);
  assign par_b      = (state_q == ST_CASET) ? 16'(x1_q) : 16'(y1_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bad_window) begin
            err_d = 1'b1;
          end else begin
            x0_d    = x0;
            x1_d    = x1;
            y0_d    = y0;
            y1_d    = y1;
            cnt_d   = span_x * span_y;
            idx_d   = 3'd0;
            state_d = ST_CASET;
          end
        end
      end
      ST_CASET, ST_RASET: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          if (idx_q == 3'd0) begin
            out_data_d = WORD_WIDTH'(mk_word(RS_CMD,
                           (state_q == ST_CASET) ? CMD_CASET : CMD_RASET));
          end else begin
            out_data_d = WORD_WIDTH'(mk_word(RS_DATA, param_byte(idx_q, par_a, par_b)));
          end
          if (idx_q == 3'd4) begin
            idx_d   = 3'd0;
            state_d = (state_q == ST_CASET) ? ST_RASET : ST_RAMWR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_RAMWR: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = WORD_WIDTH'(mk_word(RS_CMD, CMD_RAMWR));
          state_d     = ST_PIX_HI;
        end
      end
      ST_PIX_HI: begin
        if (pix_valid && slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = WORD_WIDTH'(mk_word(RS_DATA, pix_data[15:8]));
          lo_d        = pix_data[7:0];
          state_d     = ST_PIX_LO;
        end
      end
      ST_PIX_LO: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = WORD_WIDTH'(mk_word(RS_DATA, lo_q));
          cnt_d       = cnt_q - CNT_W'(1);
          state_d     = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_PIX_HI;
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      cnt_q       <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // done marks the final handshake itself, so it is qualified in that cycle.
  assign done      = rst && (state_q == ST_DONE) && out_valid_q && out_ready;
  assign pix_ready = (state_q == ST_PIX_HI) && slot_free;
  assign busy      = busy_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_window_writer.sv
// ============================================================================
// tb_lcd_window_writer : randomized scoreboard bench for lcd_window_writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_window_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  x0, x1, y0, y1;
  logic        busy, done, err;
  logic        pix_valid, pix_ready;
  logic [15:0] pix_data;
  logic        out_valid, out_ready;
  logic [8:0]  out_data;

  always #5 clk = ~clk;

  lcd_window_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .busy(busy), .done(done), .err(err),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [9:0]  exp_q[$];        // {last, word}
  logic [15:0] pix_mem[$];
  int          pix_idx = 0;
  int          pix_total = 0;
  bit          bp = 0;
  bit          gaps = 0;
  bit          pix_hs = 0;
  int          pix_hs_cnt = 0;
  int          word_cnt = 0;
  int          done_seen = 0;
  bit          stall_prev = 0;
  logic [8:0]  stall_data;
  logic [9:0]  e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    pix_hs = pix_valid && pix_ready;
    if (rst) begin
      if (stall_prev && out_valid) check("stall_hold", 32'(out_data), 32'(stall_data));
      if (out_valid && out_ready) begin
        word_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word", $sformatf("got %h, required no word", out_data));
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(out_data), 32'(e[8:0]));
          check("done_on_last", 32'(done), 32'(e[9]));
        end
      end else if (done) begin
        fail_now("spurious_done", "got done=1 without final handshake, required 0");
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (done) done_seen++;
      if (pix_hs) pix_hs_cnt++;
    end else begin
      stall_prev = 0;
      if (done) fail_now("done_in_reset", "got done=1 while rst low, required 0");
    end
  end

  // Upstream pixel source
  initial begin
    pix_valid = 1'b0;
    pix_data  = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (pix_hs) pix_idx++;
      if (pix_idx < pix_total) begin
        pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data  = pix_mem[pix_idx];
      end else begin
        pix_valid = 1'b0;
      end
    end
  end

  // Downstream FIFO backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [9:0] ent(input bit last, input bit rs, input logic [7:0] b);
    return {last, rs, b};
  endfunction

  // Reference model: command preamble then npix pixels as hi/lo byte pairs.
  task automatic build(input int ax0, input int ax1, input int ay0, input int ay1,
                       input int npix, input bit use_fixed, input logic [15:0] fixed);
    int n;
    logic [15:0] p;
    logic [15:0] c[4];
    n = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
    exp_q.delete();
    pix_mem.delete();
    exp_q.push_back(ent(0, 0, 8'h2A));
    c[0] = 16'(ax0); c[1] = 16'(ax1); c[2] = 16'(ay0); c[3] = 16'(ay1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) exp_q.push_back(ent(0, 0, 8'h2B));
      exp_q.push_back(ent(0, 1, c[k][15:8]));
      exp_q.push_back(ent(0, 1, c[k][7:0]));
    end
    exp_q.push_back(ent(0, 0, 8'h2C));
    for (int i = 0; i < npix; i++) begin
      p = use_fixed ? fixed : 16'($urandom);
      pix_mem.push_back(p);
      exp_q.push_back(ent(0, 1, p[15:8]));
      exp_q.push_back(ent(i == n - 1, 1, p[7:0]));
    end
    pix_idx   = 0;
    pix_total = npix;
  endtask

  task automatic pulse_start(input int ax0, input int ax1, input int ay0, input int ay1);
    @(posedge clk); #1;
    x0 = 9'(ax0); x1 = 9'(ax1); y0 = 9'(ay0); y1 = 9'(ay1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int c = 0;
    int d0 = done_seen;
    while (done_seen == d0 && c < limit) begin
      @(posedge clk);
      c++;
    end
    if (done_seen == d0) fail_now(name, "timeout waiting for done");
    @(negedge clk);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run(input string name, input int ax0, input int ax1, input int ay0,
                     input int ay1, input int limit);
    @(negedge clk);
    build(ax0, ax1, ay0, ay1, (ax1 - ax0 + 1) * (ay1 - ay0 + 1), 0, 16'h0);
    pulse_start(ax0, ax1, ay0, ay1);
    wait_done(name, limit);
  endtask

  task automatic abort_reset(input string name);
    int d0 = done_seen;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_no_done"}, 32'(done_seen), 32'(d0));
    exp_q.delete();
    pix_total = 0;
    pix_idx   = 0;
    rst = 1'b1;
  endtask

  initial begin
    int c, ax, ay, w, h, d0, target;
    rst = 1'b0; start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b1;

    // Single pixel, latency of first word
    @(negedge clk);
    build(10, 10, 20, 20, 1, 1, 16'h1234);
    pulse_start(10, 10, 20, 20);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_first_valid", 32'(out_valid), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    wait_done("single_px", 200);

    // 5x3 window with backpressure and upstream gaps
    bp = 1; gaps = 1;
    run("win5x3_stall", 7, 11, 30, 32, 2000);

    // Random small windows, random stall modes
    for (int t = 0; t < 4; t++) begin
      w  = $urandom_range(1, 6);
      h  = $urandom_range(1, 6);
      ax = $urandom_range(0, 240 - w);
      ay = $urandom_range(0, 320 - h);
      bp = 1'($urandom_range(0, 1)); gaps = 1'($urandom_range(0, 1));
      run("rand_win", ax, ax + w - 1, ay, ay + h - 1, 3000);
    end
    bp = 0; gaps = 0;

    // Bad windows
    pulse_start(50, 40, 0, 0);
    @(negedge clk);
    check("bad_x_err", 32'(err), 32'd1);
    check("bad_x_busy", 32'(busy), 32'd0);
    check("bad_x_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bad_x_err_pulse", 32'(err), 32'd0);
    pulse_start(0, 0, 0, 320);
    @(negedge clk);
    check("bad_y_err", 32'(err), 32'd1);
    check("bad_y_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("bad_y_err_pulse", 32'(err), 32'd0);
    pulse_start(0, 240, 0, 0);
    @(negedge clk);
    check("bad_xw_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("bad_valid_after", 32'(out_valid), 32'd0);

    // Reset during PIX_LO of pixel 7 of a 4x4 window
    @(negedge clk);
    build(100, 103, 200, 203, 16, 0, 16'h0);
    target = pix_hs_cnt + 7;
    pulse_start(100, 103, 200, 203);
    c = 0;
    while (pix_hs_cnt < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (pix_hs_cnt < target) fail_now("abort_wait", "timeout waiting for pixel 7");
    abort_reset("abort4x4");
    run("restart", 1, 2, 3, 4, 500);

    // Start repulsed during RASET is ignored
    @(negedge clk);
    build(3, 5, 9, 10, 6, 0, 16'h0);
    d0 = done_seen;
    target = word_cnt + 6;
    pulse_start(3, 5, 9, 10);
    c = 0;
    while (word_cnt < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    pulse_start(0, 0, 0, 0);
    wait_done("restart_ignored", 500);
    repeat (20) @(negedge clk);
    check("restart_one_done", 32'(done_seen - d0), 32'd1);
    check("restart_idle_valid", 32'(out_valid), 32'd0);

    // Full-screen window: preamble and first pixels, then abort
    @(negedge clk);
    build(0, 239, 0, 319, 2, 1, 16'hF800);
    pulse_start(0, 239, 0, 319);
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("full_prefix_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("full_still_busy", 32'(busy), 32'd1);
    abort_reset("full_abort");

    // Large full-width window streamed to completion
    run("wide", 0, 239, 0, 119, 70000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
